// File: rtl/wb_master_pkg.sv
// Shared types and constants for the single-beat Wishbone command initiator.
//   wb_state_e  : FSM state encoding used by wb_cmd_master
//   ST_*        : response status codes reported on rsp_status_o
package wb_master_pkg;

   // state   | meaning
   // IDLE    | ready for a command, bus idle
   // STB     | cyc=stb=1, waiting for the slave to take the strobe
   // WAIT    | strobe taken, cyc=1, waiting for ack/err/rty
   // BACKOFF | one idle cycle (cyc=0) before re-issuing after rty
   // RSP     | bus released, response pulse scheduled for next cycle
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_STB     = 3'd1,
      S_WAIT    = 3'd2,
      S_BACKOFF = 3'd3,
      S_RSP     = 3'd4
   } wb_state_e;

   localparam int unsigned ST_W = 2;

   localparam logic [ST_W-1:0] ST_OK  = 2'b00;
   localparam logic [ST_W-1:0] ST_ERR = 2'b01;
   localparam logic [ST_W-1:0] ST_RTY = 2'b10;
   localparam logic [ST_W-1:0] ST_TMO = 2'b11;

endpackage

// File: rtl/wb_cmd_master_timer.sv
// Bus-cycle watchdog for wb_cmd_master.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : reload the timer (new command accepted)
//   en_i         : count this cycle (cyc is high)
//   expired_o    : this counted cycle is the TIMEOUT-th one (or later)
// Implemented as a down-counter loaded with TIMEOUT. TIMEOUT=0 disables it.
module wb_master_timer #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   generate
      if (TIMEOUT == 0) begin : g_off
         assign expired_o = 1'b0;
      end else begin : g_on
         localparam int unsigned CW = $clog2(TIMEOUT + 1);

         logic [CW-1:0] rem_q, rem_d;

         always_comb begin
            rem_d = rem_q;
            if (clr_i) begin
               rem_d = CW'(TIMEOUT);
            end else if (en_i && (rem_q != '0)) begin
               rem_d = rem_q - CW'(1);
            end
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               rem_q <= CW'(TIMEOUT);
            end else begin
               rem_q <= rem_d;
            end
         end

         // <= rather than == so a retry re-issued after the budget is spent
         // still terminates on its first counted cycle.
         assign expired_o = en_i && (rem_q <= CW'(1));
      end
   endgenerate

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone B4 pipelined initiator.
//   req_*  : local command handshake (valid/ready) with we/adr/dat/sel
//   rsp_*  : one-cycle completion pulse with read data and status
//   wb_*   : Wishbone pipelined initiator port
// Handles stall, ack, err (highest priority), rty with MAX_RETRY re-issues
// separated by a one-cycle cyc=0 gap, and a TIMEOUT-cycle watchdog that
// spans all retries of a command. All outputs come straight from flops.
module wb_cmd_master
   import wb_master_pkg::*;
#(
   parameter int unsigned AW        = 32,
   parameter int unsigned TIMEOUT   = 256,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic            req_we_i,
   input  logic [AW-1:0]   req_adr_i,
   input  logic [31:0]     req_dat_i,
   input  logic [3:0]      req_sel_i,
   output logic            rsp_valid_o,
   output logic [31:0]     rsp_dat_o,
   output logic [ST_W-1:0] rsp_status_o,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic            wb_we_o,
   output logic [AW-1:0]   wb_adr_o,
   output logic [3:0]      wb_sel_o,
   output logic [31:0]     wb_dat_o,
   input  logic [31:0]     wb_dat_i,
   input  logic            wb_ack_i,
   input  logic            wb_err_i,
   input  logic            wb_rty_i,
   input  logic            wb_stall_i
);

   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   wb_state_e       state_q, state_d;
   logic            ready_q, ready_d;
   logic            cyc_q, cyc_d;
   logic            stb_q, stb_d;
   logic            we_q, we_d;
   logic [AW-1:0]   adr_q, adr_d;
   logic [3:0]      sel_q, sel_d;
   logic [31:0]     dat_q, dat_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [31:0]     hold_dat_q, hold_dat_d;
   logic [ST_W-1:0] hold_st_q, hold_st_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [31:0]     rsp_dat_q, rsp_dat_d;
   logic [ST_W-1:0] rsp_st_q, rsp_st_d;
   logic            tmr_clr, tmr_expired;

   wb_master_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (tmr_clr),
      .en_i     (cyc_q),
      .expired_o(tmr_expired)
   );

   always_comb begin
      state_d     = state_q;
      ready_d     = 1'b0;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      adr_d       = adr_q;
      sel_d       = sel_q;
      dat_d       = dat_q;
      retry_d     = retry_q;
      hold_dat_d  = hold_dat_q;
      hold_st_d   = hold_st_q;
      rsp_valid_d = 1'b0;
      rsp_dat_d   = rsp_dat_q;
      rsp_st_d    = rsp_st_q;
      tmr_clr     = 1'b0;

      case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            if (req_valid_i && ready_q) begin
               we_d    = req_we_i;
               adr_d   = req_adr_i;
               sel_d   = req_sel_i;
               dat_d   = req_dat_i;
               retry_d = '0;
               tmr_clr = 1'b1;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               ready_d = 1'b0;
               state_d = S_STB;
            end
         end

         S_STB, S_WAIT: begin
            if ((state_q == S_STB) && !wb_stall_i) begin
               stb_d   = 1'b0;
               state_d = S_WAIT;
            end
            // Terminations override the strobe hand-off above; a response on
            // the same edge the strobe is taken is legal in pipelined mode.
            if (wb_err_i) begin
               hold_st_d  = ST_ERR;
               hold_dat_d = '0;
               cyc_d      = 1'b0;
               stb_d      = 1'b0;
               state_d    = S_RSP;
            end else if (wb_rty_i) begin
               cyc_d = 1'b0;
               stb_d = 1'b0;
               if (retry_q < RW'(MAX_RETRY)) begin
                  retry_d = retry_q + RW'(1);
                  state_d = S_BACKOFF;
               end else begin
                  hold_st_d  = ST_RTY;
                  hold_dat_d = '0;
                  state_d    = S_RSP;
               end
            end else if (wb_ack_i) begin
               hold_st_d  = ST_OK;
               hold_dat_d = we_q ? 32'h0 : wb_dat_i;
               cyc_d      = 1'b0;
               stb_d      = 1'b0;
               state_d    = S_RSP;
            end else if (tmr_expired) begin
               hold_st_d  = ST_TMO;
               hold_dat_d = '0;
               cyc_d      = 1'b0;
               stb_d      = 1'b0;
               state_d    = S_RSP;
            end
         end

         S_BACKOFF: begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            state_d = S_STB;
         end

         S_RSP: begin
            rsp_valid_d = 1'b1;
            rsp_dat_d   = hold_dat_q;
            rsp_st_d    = hold_st_q;
            state_d     = S_IDLE;
         end

         default: begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         ready_q     <= 1'b0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         sel_q       <= '0;
         dat_q       <= '0;
         retry_q     <= '0;
         hold_dat_q  <= '0;
         hold_st_q   <= ST_OK;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_st_q    <= ST_OK;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         sel_q       <= sel_d;
         dat_q       <= dat_d;
         retry_q     <= retry_d;
         hold_dat_q  <= hold_dat_d;
         hold_st_q   <= hold_st_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_st_q    <= rsp_st_d;
      end
   end

   assign req_ready_o  = ready_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_dat_o    = rsp_dat_q;
   assign rsp_status_o = rsp_st_q;
   assign wb_cyc_o     = cyc_q;
   assign wb_stb_o     = stb_q;
   assign wb_we_o      = we_q;
   assign wb_adr_o     = adr_q;
   assign wb_sel_o     = sel_q;
   assign wb_dat_o     = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master (AW=32, TIMEOUT=16, MAX_RETRY=3).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_wb_cmd_master;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i, req_we_i;
   logic [31:0] req_adr_i, req_dat_i;
   logic [3:0]  req_sel_i;
   logic        req_ready_o, rsp_valid_o;
   logic [31:0] rsp_dat_o;
   logic [1:0]  rsp_status_o;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   wb_cmd_master #(.AW(32), .TIMEOUT(16), .MAX_RETRY(3)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
      .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_status_o(rsp_status_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
      .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i)
   );

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
      req_valid_i = 1'b1;
      req_we_i    = we;
      req_adr_i   = adr;
      req_dat_i   = dat;
      req_sel_i   = sel;
      step();
      req_valid_i = 1'b0;
   endtask

   int n;

   initial begin
      rst_i = 1'b1; req_valid_i = 0; req_we_i = 0; req_adr_i = 0; req_dat_i = 0;
      req_sel_i = 0; wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
      wb_stall_i = 0;
      step(2);
      chk("rst_ready", 32'(req_ready_o), 32'd0);
      chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
      chk("rst_rspv", 32'(rsp_valid_o), 32'd0);
      chk("rst_status", 32'(rsp_status_o), 32'd0);
      rst_i = 1'b0;
      step();
      chk("ready_after_rst", 32'(req_ready_o), 32'd1);

      // Read, no stall, ack one cycle after the strobe.
      issue(1'b0, 32'h0000_0100, 32'h0, 4'hF);
      chk("rd_cyc", 32'(wb_cyc_o), 32'd1);
      chk("rd_stb", 32'(wb_stb_o), 32'd1);
      chk("rd_we", 32'(wb_we_o), 32'd0);
      chk("rd_adr", wb_adr_o, 32'h0000_0100);
      chk("rd_ready_low", 32'(req_ready_o), 32'd0);
      step();
      chk("rd_wait_stb", 32'(wb_stb_o), 32'd0);
      chk("rd_wait_cyc", 32'(wb_cyc_o), 32'd1);
      wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_0001;
      step();
      wb_ack_i = 1'b0; wb_dat_i = 32'h0;
      chk("rd_rsp_cyc", 32'(wb_cyc_o), 32'd0);
      chk("rd_rsp_early", 32'(rsp_valid_o), 32'd0);
      step();
      chk("rd_rspv", 32'(rsp_valid_o), 32'd1);
      chk("rd_dat", rsp_dat_o, 32'hCAFE_0001);
      chk("rd_status", 32'(rsp_status_o), 32'd0);
      chk("rd_ready_gap", 32'(req_ready_o), 32'd0);
      step();
      chk("rd_rspv_pulse", 32'(rsp_valid_o), 32'd0);
      chk("rd_dat_held", rsp_dat_o, 32'hCAFE_0001);
      chk("rd_ready_back", 32'(req_ready_o), 32'd1);

      // Write with 3 stall cycles: strobe visible for 4 cycles, acked in the 4th.
      wb_stall_i = 1'b1;
      issue(1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011);
      chk("wr_stb0", 32'(wb_stb_o), 32'd1);
      chk("wr_sel", 32'(wb_sel_o), 32'h3);
      chk("wr_we", 32'(wb_we_o), 32'd1);
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("wr_stb_held", 32'(wb_stb_o), 32'd1);
         chk("wr_adr_stable", wb_adr_o, 32'h0000_0200);
         chk("wr_dat_stable", wb_dat_o, 32'h1234_5678);
      end
      wb_stall_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
      step();
      wb_ack_i = 1'b0; wb_dat_i = 32'h0;
      chk("wr_cyc_drop", 32'(wb_cyc_o), 32'd0);
      step();
      chk("wr_rspv", 32'(rsp_valid_o), 32'd1);
      chk("wr_status", 32'(rsp_status_o), 32'd0);
      chk("wr_dat_zero", rsp_dat_o, 32'h0);
      step();

      // rty twice, then ack.
      issue(1'b0, 32'h0000_0300, 32'h0, 4'hF);
      for (int i = 0; i < 2; i++) begin
         wb_rty_i = 1'b1;
         step();
         wb_rty_i = 1'b0;
         chk("rty_backoff_cyc", 32'(wb_cyc_o), 32'd0);
         chk("rty_backoff_rspv", 32'(rsp_valid_o), 32'd0);
         step();
         chk("rty_reissue_stb", 32'(wb_stb_o), 32'd1);
         chk("rty_reissue_cyc", 32'(wb_cyc_o), 32'd1);
      end
      wb_ack_i = 1'b1; wb_dat_i = 32'hA5A5_0003;
      step();
      wb_ack_i = 1'b0; wb_dat_i = 32'h0;
      step();
      chk("rty_ok_rspv", 32'(rsp_valid_o), 32'd1);
      chk("rty_ok_status", 32'(rsp_status_o), 32'd0);
      chk("rty_ok_dat", rsp_dat_o, 32'hA5A5_0003);
      step();

      // rty four times: three re-issues, then RTY reported.
      issue(1'b0, 32'h0000_0400, 32'h0, 4'hF);
      for (int i = 0; i < 3; i++) begin
         wb_rty_i = 1'b1;
         step();
         wb_rty_i = 1'b0;
         chk("rty4_backoff", 32'(wb_cyc_o), 32'd0);
         step();
         chk("rty4_reissue", 32'(wb_cyc_o), 32'd1);
      end
      wb_rty_i = 1'b1;
      step();
      wb_rty_i = 1'b0;
      chk("rty4_cyc_drop", 32'(wb_cyc_o), 32'd0);
      step();
      chk("rty4_rspv", 32'(rsp_valid_o), 32'd1);
      chk("rty4_status", 32'(rsp_status_o), 32'd2);
      chk("rty4_dat", rsp_dat_o, 32'h0);
      step();

      // Silent slave: cyc must stay high for exactly 16 cycles.
      issue(1'b0, 32'h0000_0500, 32'h0, 4'hF);
      n = 0;
      while (wb_cyc_o && n < 40) begin
         n++;
         step();
      end
      chk("tmo_cyc_cycles", 32'(n), 32'd16);
      step();
      chk("tmo_rspv", 32'(rsp_valid_o), 32'd1);
      chk("tmo_status", 32'(rsp_status_o), 32'd3);
      chk("tmo_dat", rsp_dat_o, 32'h0);
      step();

      // err and ack together: err wins.
      issue(1'b1, 32'h0000_0600, 32'h5555_AAAA, 4'hF);
      wb_err_i = 1'b1; wb_ack_i = 1'b1;
      step();
      wb_err_i = 1'b0; wb_ack_i = 1'b0;
      step();
      chk("err_rspv", 32'(rsp_valid_o), 32'd1);
      chk("err_status", 32'(rsp_status_o), 32'd1);
      step();

      // Spurious ack while idle must not produce anything.
      wb_ack_i = 1'b1; wb_dat_i = 32'h7777_7777;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("spur_rspv", 32'(rsp_valid_o), 32'd0);
         chk("spur_cyc", 32'(wb_cyc_o), 32'd0);
      end
      wb_ack_i = 1'b0; wb_dat_i = 32'h0;
      chk("spur_status_held", 32'(rsp_status_o), 32'd1);

      // Reset while waiting for the slave, then a clean read.
      issue(1'b0, 32'h0000_0700, 32'h0, 4'hF);
      step();
      chk("rstw_wait", 32'(wb_stb_o), 32'd0);
      rst_i = 1'b1;
      step();
      chk("rstw_cyc", 32'(wb_cyc_o), 32'd0);
      chk("rstw_rspv", 32'(rsp_valid_o), 32'd0);
      rst_i = 1'b0;
      step();
      chk("rstw_rspv2", 32'(rsp_valid_o), 32'd0);
      chk("rstw_ready", 32'(req_ready_o), 32'd1);
      issue(1'b0, 32'h0000_0800, 32'h0, 4'hF);
      wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_F00D;
      step();
      wb_ack_i = 1'b0; wb_dat_i = 32'h0;
      step();
      chk("post_rst_rspv", 32'(rsp_valid_o), 32'd1);
      chk("post_rst_status", 32'(rsp_status_o), 32'd0);
      chk("post_rst_dat", rsp_dat_o, 32'h0BAD_F00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
